pipe_trace_monitor: RTL and testbench
=====================================

Name: pipe_trace_monitor

Overview:
- Cycle-accurate, synthesizable run monitor that sits beside the pipelined MIPS core.
- Counts cycles, retired instructions, stalls, flushes and data-memory writes.
- Detects program completion when the PC matches a programmed finish address.
- Captures every data-memory write into a time-stamped event FIFO drained by a bench or debug port.
- Parametrised in address, data, counter and FIFO width/depth, with sticky overflow reporting.

Parameters:
AW, 32, PC and memory address width
DW, 32, write-data width
CW, 32, width of all counters and event timestamps
DEPTH, 16, event FIFO entries; power of two, >= 2
TIMEOUT, 25000, watchdog cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: IDLE -> RUN
clear  in  1  one-cycle pulse: any state -> IDLE, zeroes counters, FIFO and flags
pc  in  AW  core fetch PC
pc_finish  in  AW  finish address; sampled on the start cycle
stallD  in  1  core decode stall
flushD  in  1  core decode flush
memwrite  in  1  core data-memory write strobe
mem_addr  in  AW  write address
mem_wdata  in  DW  write data
ev_ready  in  1  consumer accepts the head event
ev_valid  out  1  FIFO non-empty
ev_addr  out  AW  head event address
ev_data  out  DW  head event data
ev_cycle  out  CW  head event timestamp
cycle_cnt  out  CW  RUN cycles
instr_cnt  out  CW  retired instructions
stall_cnt  out  CW  stallD cycles
flush_cnt  out  CW  flushD cycles
wr_cnt  out  CW  accepted memwrite events
drop_cnt  out  CW  events dropped on FIFO full
running  out  1  state == RUN
finished  out  1  state == DONE
overflow  out  1  sticky, set on the first drop
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; all counters 0; FIFO empty.
  - ev_valid, running, finished, overflow, timeout = 0.
  - ev_addr, ev_data, ev_cycle = 0.
- States IDLE, RUN, DONE. Transitions:
  - IDLE -> RUN on start; pc_finish latched into an internal register.
  - RUN -> DONE on the cycle where pc == latched finish address (match cycle).
  - DONE holds until clear.
  - clear -> IDLE from any state. clear beats start when both are high in the same cycle.
  - start in RUN or DONE is ignored.
- Counting, RUN only, on non-match cycles (the match cycle counts nothing and pushes nothing, mirroring a gated core clock):
  - cycle_cnt += 1 every cycle.
  - instr_cnt += 1 when ~stallD & ~flushD.
  - stall_cnt += 1 when stallD.
  - flush_cnt += 1 when flushD.
  - Counters wrap modulo 2^CW.
  - All counters hold in IDLE and DONE.
- Event push (RUN, non-match cycle, memwrite=1):
  - Entry is {mem_addr, mem_wdata, cycle_cnt+1}; the stamp is the 1-based index of the current cycle.
  - wr_cnt += 1 on an accepted push.
- FIFO:
  - Show-ahead: ev_* reflect the head entry combinationally from storage while ev_valid=1.
  - Pop when ev_valid & ev_ready.
  - Pops are allowed in all states, including DONE and IDLE, until clear.
  - Push while full with a pop in the same cycle is accepted; no drop.
  - Push while full without a pop: entry discarded, drop_cnt += 1, overflow set (sticky until clear/reset). wr_cnt is not incremented.
  - Pointers are log2(DEPTH)+1 bits wide with wrap-bit full/empty detection.
- Latency:
  - Counter and flag outputs update one clock after the qualifying cycle.
  - A pushed event is visible on ev_valid one clock after the push.
- Reset asserted mid-run aborts immediately to the reset state; no partial counts are retained.

Optional Feature:
- Macro: PIPE_TRACE_MONITOR_WATCHDOG_EN.
- Defined: in RUN, when cycle_cnt reaches TIMEOUT without a match, the block moves to DONE the next clock, sets timeout=1 and finished=1. A match on the same cycle takes priority: timeout stays 0.
- Undefined: timeout is tied to 0, the TIMEOUT parameter is unused, and no watchdog logic is built.

Test Plan:
- Finish detect: reset, start with pc_finish=0x40; pc steps 0x00, 0x04, ... one word per cycle with no stalls. Required: finished=1 one clock after pc=0x40; cycle_cnt=16, instr_cnt=16.
- Stall/flush accounting: stallD high for 3 cycles and flushD high for 2 distinct cycles over a 20-cycle run. Required: stall_cnt=3, flush_cnt=2, instr_cnt=15, cycle_cnt=20.
- Event capture: memwrite on cycles 5 and 9 with (0x54, 0x7) and (0x50, 0x2), ev_ready=1 after finish. Required: events pop in order with ev_cycle=5 then 9; wr_cnt=2.
- Overflow: DEPTH=4, 6 writes with ev_ready=0. Required: 4 entries held, drop_cnt=2, overflow=1; a simultaneous push and pop while full causes no drop.
- Match-cycle gating and clear priority: memwrite asserted on the match cycle is not captured. start and clear asserted together leave the block in IDLE with all counters 0.
- Watchdog (macro defined, TIMEOUT=100, pc never matches): finished=1 and timeout=1 after cycle 100; macro undefined: block stays in RUN and timeout=0.

Source files
------------

// File: rtl/pipe_trace_monitor_if.sv
// Event channel between pipe_trace_monitor and whatever drains its capture
// FIFO (bench or debug port). Valid/ready handshake with a show-ahead head.
interface pipe_trace_monitor_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 32
);
  logic          ev_valid;
  logic          ev_ready;
  logic [AW-1:0] ev_addr;
  logic [DW-1:0] ev_data;
  logic [CW-1:0] ev_cycle;

  // Producer side: the monitor presents the head event.
  modport master (
    output ev_valid, ev_addr, ev_data, ev_cycle,
    input  ev_ready
  );

  // Consumer side: accepts the head event with ev_ready.
  modport slave (
    input  ev_valid, ev_addr, ev_data, ev_cycle,
    output ev_ready
  );
endinterface

// File: rtl/pipe_trace_monitor.sv
// Run monitor for the pipelined MIPS core.
// Counts RUN cycles, retired instructions, decode stalls/flushes and data
// memory writes; stops when the fetch PC hits the finish address latched at
// start; records every data-memory write as a time-stamped event in a
// show-ahead FIFO with sticky overflow reporting.
// Optional watchdog: define PIPE_TRACE_MONITOR_WATCHDOG_EN to end a run that
// reaches TIMEOUT counted cycles without a finish match.
module pipe_trace_monitor #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int CW      = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 25000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          clear,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] pc_finish,
  input  logic          stallD,
  input  logic          flushD,
  input  logic          memwrite,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  pipe_trace_monitor_if.master ev,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] instr_cnt,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] drop_cnt,
  output logic          running,
  output logic          finished,
  output logic          overflow,
  output logic          timeout
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cyc;
  } entry_t;

  state_t        state;
  logic [AW-1:0] fin_q;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  logic match;
  logic active;
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic push_ok;
  logic drop;
  logic stop_run;

  // The match cycle behaves like a gated core clock: nothing counts or pushes.
  assign match  = (state == RUN) && (pc == fin_q);
  assign active = (state == RUN) && !match;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign push    = active && memwrite;
  assign pop     = !empty && ev.ev_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

`ifdef PIPE_TRACE_MONITOR_WATCHDOG_EN
  logic wd_hit;

  // Fires on the counted cycle that brings cycle_cnt up to TIMEOUT.
  assign wd_hit   = active && (cycle_cnt == CW'(TIMEOUT - 1));
  assign stop_run = match || wd_hit;

  // Sticky watchdog flag, cleared only by clear or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout <= 1'b0;
    end else if (clear) begin
      timeout <= 1'b0;
    end else if (wd_hit) begin
      timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign stop_run       = match;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Run-control FSM with registered running/finished flags.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fin_q    <= '0;
      running  <= 1'b0;
      finished <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      running  <= 1'b0;
      finished <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            fin_q   <= pc_finish;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (stop_run) begin
            state    <= DONE;
            running  <= 1'b0;
            finished <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state    <= IDLE;
          running  <= 1'b0;
          finished <= 1'b0;
        end
      endcase
    end
  end

  // Performance counters and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wr_cnt    <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wr_cnt    <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (active) begin
        cycle_cnt <= cycle_cnt + CW'(1);
        if (!stallD && !flushD) instr_cnt <= instr_cnt + CW'(1);
        if (stallD)             stall_cnt <= stall_cnt + CW'(1);
        if (flushD)             flush_cnt <= flush_cnt + CW'(1);
      end
      if (push_ok) wr_cnt <= wr_cnt + CW'(1);
      if (drop) begin
        drop_cnt <= drop_cnt + CW'(1);
        overflow <= 1'b1;
      end
    end
  end

  // FIFO read/write pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Event storage; the stamp is the 1-based index of the pushing cycle.
  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, and the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[PW-1:0]] <= '{addr: mem_addr, data: mem_wdata, cyc: cycle_cnt + CW'(1)};
    end
  end

  // Show-ahead head of the FIFO.
  assign head        = mem[rd_ptr[PW-1:0]];
  assign ev.ev_valid = !empty;
  assign ev.ev_addr  = empty ? '0 : head.addr;
  assign ev.ev_data  = empty ? '0 : head.data;
  assign ev.ev_cycle = empty ? '0 : head.cyc;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Self-checking bench for pipe_trace_monitor: table-driven runs plus
// hand-written corner sequences, with an event scoreboard.
module tb_pipe_trace_monitor;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int CW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] pc_finish = '0;
  logic          stallD = 1'b0;
  logic          flushD = 1'b0;
  logic          memwrite = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [CW-1:0] cycle_cnt, instr_cnt, stall_cnt, flush_cnt, wr_cnt, drop_cnt;
  logic          running, finished, overflow, timeout;

  pipe_trace_monitor_if #(.AW(AW), .DW(DW), .CW(CW)) ev_bus ();

  pipe_trace_monitor #(
    .AW(AW), .DW(DW), .CW(CW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .pc(pc), .pc_finish(pc_finish), .stallD(stallD), .flushD(flushD),
    .memwrite(memwrite), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ev(ev_bus),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .wr_cnt(wr_cnt), .drop_cnt(drop_cnt),
    .running(running), .finished(finished), .overflow(overflow),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cyc;
  } ev_t;

  typedef struct {
    int          n;
    logic [31:0] st_m;
    logic [31:0] fl_m;
    logic [31:0] wr_m;
    logic        rdy;
    int          e_cyc, e_ins, e_stl, e_fls, e_wr;
  } vec_t;

  ev_t  sb [$];
  vec_t vecs [6];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare the head event against the scoreboard when it will be popped.
  task automatic sb_check();
    ev_t e;
    if (ev_bus.ev_valid && ev_bus.ev_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ev_unexpected: got addr %0h expected no event", ev_bus.ev_addr);
      end else begin
        e = sb.pop_front();
        check("ev_addr",  64'(ev_bus.ev_addr),  64'(e.addr));
        check("ev_data",  64'(ev_bus.ev_data),  64'(e.data));
        check("ev_cycle", 64'(ev_bus.ev_cycle), 64'(e.cyc));
      end
    end
  endtask

  task automatic step();
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    stallD   = 1'b0;
    flushD   = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic do_clear();
    quiet();
    start = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    sb.delete();
  endtask

  task automatic begin_run(input logic [AW-1:0] fin);
    quiet();
    pc        = 32'hDEAD_0000;
    pc_finish = fin;
    start     = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    quiet();
    ev_bus.ev_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH + 4 && (sb.size() != 0 || ev_bus.ev_valid); k++) step();
    check({tag, " sb_left"}, 64'(sb.size()), 64'd0);
    check({tag, " ev_valid_drained"}, 64'(ev_bus.ev_valid), 64'd0);
    ev_bus.ev_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    ev_t e;
    //         n   stall     flush     write     rdy  cyc ins stl fls wr
    vecs[0] = '{16, 32'h0,    32'h0,    32'h0,    1'b1, 16, 16, 0, 0, 0};
    vecs[1] = '{0,  32'h0,    32'h0,    32'h1,    1'b1, 0,  0,  0, 0, 0};
    vecs[2] = '{1,  32'h0,    32'h0,    32'h1,    1'b1, 1,  1,  0, 0, 1};
    vecs[3] = '{5,  32'h1F,   32'h1F,   32'h7,    1'b0, 5,  0,  5, 5, 3};
    vecs[4] = '{20, 32'h1C,   32'h1100, 32'h0,    1'b1, 20, 15, 3, 2, 0};
    vecs[5] = '{10, 32'h2,    32'h0,    32'h609,  1'b1, 10, 9,  1, 0, 3};

    ev_bus.ev_ready = 1'b0;

    // Reset state.
    #3;
    check("rst running",   64'(running),         64'd0);
    check("rst finished",  64'(finished),        64'd0);
    check("rst overflow",  64'(overflow),        64'd0);
    check("rst timeout",   64'(timeout),         64'd0);
    check("rst ev_valid",  64'(ev_bus.ev_valid), 64'd0);
    check("rst ev_addr",   64'(ev_bus.ev_addr),  64'd0);
    check("rst ev_cycle",  64'(ev_bus.ev_cycle), 64'd0);
    check("rst cycle_cnt", 64'(cycle_cnt),       64'd0);
    check("rst wr_cnt",    64'(wr_cnt),          64'd0);
    #9 reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven runs: pc steps one word per cycle until it hits n*4.
    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      do_clear();
      begin_run(AW'(v.n * 4));
      for (int i = 0; i <= v.n; i++) begin
        pc              = AW'(i * 4);
        stallD          = v.st_m[i];
        flushD          = v.fl_m[i];
        memwrite        = v.wr_m[i];
        mem_addr        = AW'(32'h1000 + i * 8);
        mem_wdata       = DW'(32'hA500 + i);
        ev_bus.ev_ready = v.rdy;
        if (i < v.n && v.wr_m[i]) begin
          e = '{addr: mem_addr, data: mem_wdata, cyc: CW'(i + 1)};
          sb.push_back(e);
        end
        if (i == v.n) check($sformatf("v%0d running_at_match", k), 64'(running), 64'd1);
        step();
      end
      quiet();
      check($sformatf("v%0d finished",  k), 64'(finished),  64'd1);
      check($sformatf("v%0d running",   k), 64'(running),   64'd0);
      check($sformatf("v%0d cycle_cnt", k), 64'(cycle_cnt), 64'(v.e_cyc));
      check($sformatf("v%0d instr_cnt", k), 64'(instr_cnt), 64'(v.e_ins));
      check($sformatf("v%0d stall_cnt", k), 64'(stall_cnt), 64'(v.e_stl));
      check($sformatf("v%0d flush_cnt", k), 64'(flush_cnt), 64'(v.e_fls));
      check($sformatf("v%0d wr_cnt",    k), 64'(wr_cnt),    64'(v.e_wr));
      check($sformatf("v%0d drop_cnt",  k), 64'(drop_cnt),  64'd0);
      // DONE holds and ignores start.
      pc    = 32'h0;
      start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("v%0d done_hold", k),  64'(finished),  64'd1);
      check($sformatf("v%0d cycle_hold", k), 64'(cycle_cnt), 64'(v.e_cyc));
      drain($sformatf("v%0d", k));
    end

    // clear beats start: from DONE with nonzero counters back to IDLE.
    start = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    clear = 1'b0;
    check("clr running",   64'(running),   64'd0);
    check("clr finished",  64'(finished),  64'd0);
    check("clr cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("clr instr_cnt", 64'(instr_cnt), 64'd0);
    check("clr wr_cnt",    64'(wr_cnt),    64'd0);
    step();
    check("clr still_idle", 64'(running), 64'd0);

    // Event capture with exact addresses, consumer idle until finish.
    do_clear();
    begin_run(32'h40);
    for (int i = 0; i <= 16; i++) begin
      pc       = AW'(i * 4);
      memwrite = (i == 4) || (i == 8);
      mem_addr  = (i == 4) ? 32'h54 : 32'h50;
      mem_wdata = (i == 4) ? 32'h7  : 32'h2;
      if (memwrite && i < 16) begin
        e = '{addr: mem_addr, data: mem_wdata, cyc: CW'(i + 1)};
        sb.push_back(e);
      end
      step();
    end
    quiet();
    check("cap wr_cnt",   64'(wr_cnt),          64'd2);
    check("cap ev_valid", 64'(ev_bus.ev_valid), 64'd1);
    check("cap head_adr", 64'(ev_bus.ev_addr),  64'h54);
    check("cap head_cyc", 64'(ev_bus.ev_cycle), 64'd5);
    drain("cap");

    // Overflow: 6 writes into 4 entries, then push+pop while full.
    do_clear();
    begin_run(32'h1000);
    ev_bus.ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pc        = AW'(i * 4);
      memwrite  = 1'b1;
      mem_addr  = AW'(32'h2000 + i * 4);
      mem_wdata = DW'(32'h100 + i);
      if (i < 4) begin
        e = '{addr: mem_addr, data: mem_wdata, cyc: CW'(i + 1)};
        sb.push_back(e);
      end
      step();
    end
    check("ovf drop_cnt", 64'(drop_cnt), 64'd2);
    check("ovf overflow", 64'(overflow), 64'd1);
    check("ovf wr_cnt",   64'(wr_cnt),   64'd4);
    pc              = 32'h18;
    mem_addr        = 32'h2018;
    mem_wdata       = 32'h106;
    ev_bus.ev_ready = 1'b1;
    e = '{addr: mem_addr, data: mem_wdata, cyc: CW'(7)};
    sb.push_back(e);
    step();
    check("ovf pp_drop", 64'(drop_cnt), 64'd2);
    check("ovf pp_wr",   64'(wr_cnt),   64'd5);
    drain("ovf");
    check("ovf sticky",  64'(overflow), 64'd1);
    check("ovf running", 64'(running),  64'd1);
    do_clear();
    check("ovf clr_flag", 64'(overflow), 64'd0);
    check("ovf clr_drop", 64'(drop_cnt), 64'd0);

    // Watchdog: finish address never reached.
    do_clear();
    begin_run(32'hFFFF_FFF0);
    for (int i = 0; i < 100; i++) begin
      pc = AW'(i * 4);
      step();
    end
    check("wd cycle_cnt", 64'(cycle_cnt), 64'd100);
`ifdef PIPE_TRACE_MONITOR_WATCHDOG_EN
    check("wd finished", 64'(finished), 64'd1);
    check("wd timeout",  64'(timeout),  64'd1);
    check("wd running",  64'(running),  64'd0);
`else
    check("wd running",  64'(running),  64'd1);
    check("wd timeout",  64'(timeout),  64'd0);
    pc = 32'h190;
    step();
    check("wd keeps_run", 64'(cycle_cnt), 64'd101);
`endif

    // Reset mid-run aborts immediately.
    do_clear();
    begin_run(32'h400);
    for (int i = 0; i < 4; i++) begin
      pc        = AW'(i * 4);
      memwrite  = 1'b1;
      mem_addr  = AW'(32'h3000 + i * 4);
      mem_wdata = DW'(i);
      step();
    end
    quiet();
    #2 reset = 1'b0;
    #1;
    check("arst running",  64'(running),         64'd0);
    check("arst cycle",    64'(cycle_cnt),       64'd0);
    check("arst wr_cnt",   64'(wr_cnt),          64'd0);
    check("arst ev_valid", 64'(ev_bus.ev_valid), 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("arst idle", 64'(running), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
